// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV M-extension multiply/divide execute unit
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic             in_is_word_op,
    input  logic [XLEN-1:0]  in_a,
    input  logic [XLEN-1:0]  in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);
    localparam int   CW   = $clog2(XLEN);
    localparam logic IS64 = (XLEN == 64);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    // Op context captured at accept
    logic [2:0]        op_r;
    logic              word_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic [CW-1:0]     cnt;

    // Multiply uses acc (product), mcand (shifted multiplicand), opb (multiplier).
    // Divide uses acc[XLEN-1:0] (partial remainder), quo (dividend in / quotient out), opb (divisor).
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] mcand;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   quo;

    logic              accept;
    logic              eff_word;
    logic              a_signed;
    logic              b_signed;
    logic              sa;
    logic              sb;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   a_ext;
    logic [XLEN-1:0]   b_ext;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic [XLEN-1:0]   min_val;
    logic [XLEN-1:0]   a_res;
    logic [XLEN-1:0]   fast_result;

    logic [2*XLEN-1:0] mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     diff;
    logic              qbit;
    logic [XLEN-1:0]   rem_new;
    logic [XLEN-1:0]   quo_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   raw;
    logic [XLEN-1:0]   fin_result;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    assign in_ready  = (state == IDLE) & ~flush;
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;

    // Decode a request: effective width, operand magnitudes/signs and fast-path outcome
    always_comb begin
        eff_word = IS64 & in_is_word_op & ((in_op == 3'b000) | in_op[2]);
        a_signed = (in_op == 3'b000) | (in_op == 3'b001) | (in_op == 3'b010)
                 | (in_op == 3'b100) | (in_op == 3'b110);
        b_signed = (in_op == 3'b000) | (in_op == 3'b001)
                 | (in_op == 3'b100) | (in_op == 3'b110);
        a_ext    = eff_word ? (a_signed ? sext32(in_a[31:0]) : XLEN'(in_a[31:0])) : in_a;
        b_ext    = eff_word ? (b_signed ? sext32(in_b[31:0]) : XLEN'(in_b[31:0])) : in_b;
        sa       = a_signed & a_ext[XLEN-1];
        sb       = b_signed & b_ext[XLEN-1];
        mag_a    = sa ? -a_ext : a_ext;
        mag_b    = sb ? -b_ext : b_ext;
        min_val  = eff_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = (b_ext == '0);
        div_ovf  = ((in_op == 3'b100) | (in_op == 3'b110)) & (a_ext == min_val) & (b_ext == '1);
        fast     = in_op[2] & (div_zero | div_ovf);
        a_res    = eff_word ? sext32(in_a[31:0]) : in_a;
        if (div_zero) begin
            fast_result = in_op[1] ? a_res : '1;
        end else begin
            fast_result = in_op[1] ? '0 : a_res;
        end
    end

    // One shift-add / restoring-subtract step, plus sign fixup of the post-step values
    always_comb begin
        mul_sum  = acc + (opb[0] ? mcand : '0);
        rem_sh   = {acc[XLEN-1:0], quo[XLEN-1]};
        diff     = rem_sh - {1'b0, opb};
        qbit     = ~diff[XLEN];
        rem_new  = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_step = {quo[XLEN-2:0], qbit};
        prod     = neg_q_r ? -mul_sum : mul_sum;
        quo_fix  = neg_q_r ? -quo_step : quo_step;
        rem_fix  = neg_r_r ? -rem_new : rem_new;
        if (!op_r[2]) begin
            raw = (op_r[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end else begin
            raw = op_r[1] ? rem_fix : quo_fix;
        end
        fin_result = word_r ? sext32(raw[31:0]) : raw;
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = fast ? DONE : BUSY;
            BUSY: if (cnt == '0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture at accept, iteration while busy, result/tag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= '0;
            word_r     <= 1'b0;
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            opb        <= '0;
            quo        <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (accept) begin
            op_r    <= in_op;
            word_r  <= eff_word;
            neg_q_r <= sa ^ sb;
            neg_r_r <= sa;
            cnt     <= eff_word ? CW'(31) : CW'(XLEN - 1);
            acc     <= '0;
            mcand   <= {{XLEN{1'b0}}, mag_a};
            opb     <= mag_b;
            // Left-align a word dividend so the top iteration sees its bit 31
            quo     <= eff_word ? (mag_a << (XLEN - 32)) : mag_a;
            out_tag <= in_tag;
            if (fast) out_result <= fast_result;
        end else if ((state == BUSY) && !flush) begin
            cnt <= cnt - CW'(1);
            if (op_r[2]) begin
                acc <= {{XLEN{1'b0}}, rem_new};
                quo <= quo_step;
            end else begin
                acc   <= mul_sum;
                mcand <= mcand << 1;
                opb   <= opb >> 1;
            end
            if (cnt == '0) out_result <= fin_result;
        end
    end
endmodule
